// File: rtl/mem_responder.sv
// Valid/ready memory responder: word RAM with byte enables and a programmable response latency.
// Defining MEM_RESPONDER_JITTER_EN adds 0..3 LFSR-driven wait states per request.
module mem_responder #(
   parameter int unsigned           ADDR_WIDTH  = 32,
   parameter int unsigned           WORD_WIDTH  = 32,
   parameter int unsigned           DEPTH_WORDS = 4096,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int unsigned           LATENCY     = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_valid_i,
   output logic                  mem_ready_o,
   input  logic [ADDR_WIDTH-1:0] mem_addr_i,
   input  logic [WORD_WIDTH-1:0] mem_wdata_i,
   input  logic [3:0]            mem_we_i,
   output logic [WORD_WIDTH-1:0] mem_rdata_o,
   output logic                  err_o
);
   // state  | meaning
   // S_IDLE | waiting for mem_valid_i; request captured on acceptance
   // S_WAIT | latency countdown; leaving mem_valid_i low aborts the request
   // S_RESP | one-cycle ready strobe; write lanes commit at the edge that ends it

   localparam int unsigned         IDX_W     = $clog2(DEPTH_WORDS);
   localparam logic [ADDR_WIDTH:0] SPAN      = (ADDR_WIDTH+1)'(DEPTH_WORDS) << 2;
   localparam logic [4:0]          LOAD_BASE = 5'(LATENCY - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                state_q, state_d;
   logic [4:0]            cnt_q, cnt_d, cnt_load, extra;
   logic                  ready_q, ready_d, err_q, err_d;
   logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
   logic [IDX_W-1:0]      idx_q, idx_in, rd_idx;
   logic [WORD_WIDTH-1:0] wdata_q;
   logic [3:0]            we_q;
   logic                  inr_q, inr_in, rd_inr, accept;
   logic [ADDR_WIDTH-1:0] offs;
   logic [WORD_WIDTH-1:0] mem_q [DEPTH_WORDS];

   // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
   assign offs   = mem_addr_i - BASE_ADDR;
   assign inr_in = {1'b0, offs} < SPAN;
   assign idx_in = offs[IDX_W+1:2];

`ifdef MEM_RESPONDER_JITTER_EN
   logic [7:0] lfsr_q, lfsr_d;
   assign lfsr_d = accept ? {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]} : lfsr_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr_q <= 8'hA5;
      else     lfsr_q <= lfsr_d;
   end
   assign extra = {3'b000, lfsr_q[1:0]};
`else
   assign extra = 5'd0;
`endif

   assign cnt_load = LOAD_BASE + extra;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (mem_valid_i) begin
               accept  = 1'b1;
               cnt_d   = cnt_load;
               state_d = (cnt_load == 5'd0) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            if (!mem_valid_i) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 5'd1;
               if (cnt_q == 5'd1) state_d = S_RESP;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // A request accepted straight into RESP has not been captured yet, so use the live inputs.
   assign rd_idx = (state_q == S_IDLE) ? idx_in : idx_q;
   assign rd_inr = (state_q == S_IDLE) ? inr_in : inr_q;

   always_comb begin
      ready_d = 1'b0;
      err_d   = 1'b0;
      rdata_d = '0;
      if (state_d == S_RESP) begin
         ready_d = 1'b1;
         if (rd_inr) rdata_d = mem_q[rd_idx];
         else        err_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         idx_q   <= '0;
         inr_q   <= 1'b0;
         wdata_q <= '0;
         we_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         if (accept) begin
            idx_q   <= idx_in;
            inr_q   <= inr_in;
            wdata_q <= mem_wdata_i;
            we_q    <= mem_we_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == S_RESP && inr_q) begin
         for (int i = 0; i < 4; i++)
            if (we_q[i]) mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
   end

   assign mem_ready_o = ready_q;
   assign err_o       = err_q;
   assign mem_rdata_o = rdata_q;
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized traffic
// against a word-array reference model (LFSR jitter modelled when MEM_RESPONDER_JITTER_EN is set).
module tb_mem_responder;
   localparam int          LAT   = 3;
   localparam int          DEPTH = 4096;
   localparam logic [31:0] BASE  = 32'h0;
   localparam int          TMO   = 40;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_valid_i = 1'b0;
   logic        mem_ready_o;
   logic [31:0] mem_addr_i = '0;
   logic [31:0] mem_wdata_i = '0;
   logic [3:0]  mem_we_i = '0;
   logic [31:0] mem_rdata_o;
   logic        err_o;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] model [int];
   logic [7:0]  lfsr_m = 8'hA5;

   mem_responder #(
      .ADDR_WIDTH(32), .WORD_WIDTH(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)
   ) dut (
      .clk(clk), .rst(rst),
      .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o),
      .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_we_i(mem_we_i),
      .mem_rdata_o(mem_rdata_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   // Whenever no response is presented, data and error must be quiet.
   always @(negedge clk) begin
      if (!rst && mem_ready_o === 1'b0) begin
         checks++;
         if (mem_rdata_o !== 32'h0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_quiet t=%0t rdata=%h err=%b want 00000000/0", $time, mem_rdata_o, err_o);
         end
      end
   end

   // Extra wait states for the next accepted request; taps of x^8+x^6+x^5+x^4+1 are bits 7,5,4,3.
   function automatic int next_extra();
      int e;
      e = 0;
`ifdef MEM_RESPONDER_JITTER_EN
      e = int'(lfsr_m[1:0]);
      lfsr_m = {lfsr_m[6:0], ^(lfsr_m & 8'hB8)};
`endif
      return e;
   endfunction

   // Reference memory: returns the word as it was before this transfer and applies any write.
   function automatic logic [31:0] ref_xfer(input logic [31:0] a, input logic [31:0] wd,
                                            input logic [3:0] we, output logic oob);
      logic [31:0] off, old, upd;
      int idx;
      off = a - BASE;
      idx = int'(off / 4);
      oob = !(off < 32'(DEPTH * 4));
      if (oob) return 32'h0;
      old = model.exists(idx) ? model[idx] : 32'h0;
      upd = old;
      for (int b = 0; b < 4; b++) if (we[b]) upd[8*b +: 8] = wd[8*b +: 8];
      model[idx] = upd;
      return old;
   endfunction

   // Issue one request from a negedge; lat counts rising edges until ready is seen (-1 = timeout).
   task automatic do_xfer(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                          input bit hold, output logic [31:0] rd, output logic er,
                          output int lat, output bit pulse_ok);
      mem_valid_i = 1'b1; mem_addr_i = a; mem_wdata_i = wd; mem_we_i = we;
      lat = 0;
      do begin
         @(posedge clk); lat++; @(negedge clk);
      end while (mem_ready_o !== 1'b1 && lat < TMO);
      if (mem_ready_o !== 1'b1) lat = -1;
      rd = mem_rdata_o; er = err_o;
      @(posedge clk); @(negedge clk);
      pulse_ok = (mem_ready_o === 1'b0);
      if (!hold) mem_valid_i = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst = 1'b1; mem_valid_i = 1'b0;
      #1;
      checks++;
      if (mem_ready_o !== 1'b0 || err_o !== 1'b0 || mem_rdata_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs ready=%b err=%b rdata=%h want 0/0/00000000", mem_ready_o, err_o, mem_rdata_o);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0; lfsr_m = 8'hA5;
      @(negedge clk);
   endtask

   task automatic test_read_after_reset();
      logic [31:0] rd, ex; logic er, eo; int lat, el; bit p;
      ex = ref_xfer(32'h0, 32'h0, 4'hF, eo); el = LAT + next_extra();
      do_xfer(32'h0, 32'h0, 4'hF, 1'b0, rd, er, lat, p);
      checks++;
      if (lat != el || er !== 1'b0) begin errors++; $display("FAIL clear_write lat=%0d err=%b want %0d/0", lat, er, el); end
      ex = ref_xfer(32'h0, 32'h0, 4'h0, eo); el = LAT + next_extra();
      do_xfer(32'h0, 32'h0, 4'h0, 1'b0, rd, er, lat, p);
      checks++;
      if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL first_read rdata=%h err=%b want 00000000/0", rd, er); end
      checks++;
      if (lat != el || !p) begin errors++; $display("FAIL first_read_timing lat=%0d pulse=%0b want %0d/1", lat, p, el); end
   endtask

   task automatic test_byte_lanes();
      logic [31:0] rd, ex; logic er, eo; int lat, el; bit p;
      ex = ref_xfer(32'h10, 32'hDEADBEEF, 4'hF, eo); el = LAT + next_extra();
      do_xfer(32'h10, 32'hDEADBEEF, 4'hF, 1'b0, rd, er, lat, p);
      checks++;
      if (lat != el || er !== 1'b0 || !p) begin errors++; $display("FAIL full_write lat=%0d err=%b want %0d/0", lat, er, el); end
      ex = ref_xfer(32'h10, 32'h0000AA00, 4'b0010, eo); el = LAT + next_extra();
      do_xfer(32'h10, 32'h0000AA00, 4'b0010, 1'b0, rd, er, lat, p);
      checks++;
      if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL partial_write_preword rdata=%h want deadbeef", rd); end
      ex = ref_xfer(32'h10, 32'h0, 4'h0, eo); el = LAT + next_extra();
      do_xfer(32'h10, 32'h0, 4'h0, 1'b0, rd, er, lat, p);
      checks++;
      if (rd !== 32'hDEADAAEF || er !== 1'b0 || lat != el) begin
         errors++; $display("FAIL lane_merge rdata=%h err=%b lat=%0d want deadaaef/0/%0d", rd, er, lat, el);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd, ex; logic er, eo; int lat, el; bit p;
      for (int i = 0; i < 8; i++) begin
         ex = ref_xfer(32'h10, 32'h0, 4'h0, eo); el = LAT + next_extra();
         do_xfer(32'h10, 32'h0, 4'h0, 1'b1, rd, er, lat, p);
         checks++;
         if (lat != el || !p || rd !== 32'hDEADAAEF) begin
            errors++;
            $display("FAIL b2b_read[%0d] lat=%0d pulse=%0b rdata=%h want %0d/1/deadaaef", i, lat, p, rd, el);
         end
      end
      mem_valid_i = 1'b0;
   endtask

   typedef struct {
      logic [31:0] a; logic [31:0] wd; logic [3:0] we; bit chk_rd; logic [31:0] rd; logic err;
   } oob_vec_t;

   task automatic test_out_of_range();
      oob_vec_t v [7];
      logic [31:0] rd, ex; logic er, eo; int lat, el; bit p;
      v[0] = '{32'h0000_3FFC, 32'h0102_0304, 4'hF, 1'b0, 32'h0,         1'b0};
      v[1] = '{32'h0000_4000, 32'h1234_5678, 4'hF, 1'b1, 32'h0,         1'b1};
      v[2] = '{32'h0000_4000, 32'h0,         4'h0, 1'b1, 32'h0,         1'b1};
      v[3] = '{32'hFFFF_FFFC, 32'hAAAA_AAAA, 4'hF, 1'b1, 32'h0,         1'b1};
      v[4] = '{32'h0000_0000, 32'h0,         4'h0, 1'b1, 32'h0,         1'b0};
      v[5] = '{32'h0000_3FFC, 32'h0,         4'h0, 1'b1, 32'h0102_0304, 1'b0};
      v[6] = '{32'h0000_3FFE, 32'h0,         4'h0, 1'b1, 32'h0102_0304, 1'b0};
      for (int i = 0; i < 7; i++) begin
         ex = ref_xfer(v[i].a, v[i].wd, v[i].we, eo); el = LAT + next_extra();
         do_xfer(v[i].a, v[i].wd, v[i].we, 1'b0, rd, er, lat, p);
         checks++;
         if (er !== v[i].err || (v[i].chk_rd && rd !== v[i].rd) || lat != el) begin
            errors++;
            $display("FAIL range[%0d] addr=%h err=%b rdata=%h lat=%0d want %b/%h/%0d", i, v[i].a, er, rd, lat, v[i].err, v[i].rd, el);
         end
      end
   endtask

   task automatic test_abort();
      logic [31:0] rd, ex; logic er, eo; int lat, el; bit p; bit seen;
      ex = ref_xfer(32'h20, 32'h55AA55AA, 4'hF, eo); el = LAT + next_extra();
      do_xfer(32'h20, 32'h55AA55AA, 4'hF, 1'b0, rd, er, lat, p);
      $display("note: initiator drops valid during WAIT (protocol violation, expect silent abort)");
      mem_valid_i = 1'b1; mem_addr_i = 32'h20; mem_wdata_i = 32'hFFFFFFFF; mem_we_i = 4'hF;
      el = next_extra();
      @(posedge clk); @(negedge clk);
      mem_valid_i = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
         if (mem_ready_o !== 1'b0) seen = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (seen) begin errors++; $display("FAIL abort_ready ready seen=1 want 0"); end
      ex = ref_xfer(32'h20, 32'h0, 4'h0, eo); el = LAT + next_extra();
      do_xfer(32'h20, 32'h0, 4'h0, 1'b0, rd, er, lat, p);
      checks++;
      if (rd !== 32'h55AA55AA || lat != el) begin errors++; $display("FAIL abort_nowrite rdata=%h lat=%0d want 55aa55aa/%0d", rd, lat, el); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd, ex; logic er, eo; int lat, el; bit p; bit seen;
      ex = ref_xfer(32'h30, 32'h13572468, 4'hF, eo); el = LAT + next_extra();
      do_xfer(32'h30, 32'h13572468, 4'hF, 1'b0, rd, er, lat, p);
      mem_valid_i = 1'b1; mem_addr_i = 32'h30; mem_wdata_i = 32'hFFFFFFFF; mem_we_i = 4'hF;
      @(posedge clk); @(posedge clk); @(negedge clk);
      rst = 1'b1; mem_valid_i = 1'b0;
      #1;
      checks++;
      if (mem_ready_o !== 1'b0 || mem_rdata_o !== 32'h0 || err_o !== 1'b0) begin
         errors++; $display("FAIL reset_wait_outputs ready=%b rdata=%h err=%b want 0/0/0", mem_ready_o, mem_rdata_o, err_o);
      end
      @(negedge clk);
      rst = 1'b0; lfsr_m = 8'hA5;
      seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
         if (mem_ready_o !== 1'b0) seen = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (seen) begin errors++; $display("FAIL reset_wait_ready ready seen=1 want 0"); end
      ex = ref_xfer(32'h30, 32'h0, 4'h0, eo); el = LAT + next_extra();
      do_xfer(32'h30, 32'h0, 4'h0, 1'b0, rd, er, lat, p);
      checks++;
      if (rd !== 32'h13572468 || lat != el) begin errors++; $display("FAIL reset_wait_nowrite rdata=%h lat=%0d want 13572468/%0d", rd, lat, el); end
   endtask

   task automatic test_reset_in_resp();
      logic [31:0] rd, ex; logic er, eo; int lat, el; bit p; int n;
      ex = ref_xfer(32'h40, 32'hCAFEF00D, 4'hF, eo); el = LAT + next_extra();
      do_xfer(32'h40, 32'hCAFEF00D, 4'hF, 1'b0, rd, er, lat, p);
      mem_valid_i = 1'b1; mem_addr_i = 32'h40; mem_wdata_i = 32'h0; mem_we_i = 4'hF;
      el = next_extra();
      n = 0;
      do begin @(negedge clk); n++; end while (mem_ready_o !== 1'b1 && n < TMO);
      checks++;
      if (mem_ready_o !== 1'b1 || mem_rdata_o !== 32'hCAFEF00D) begin
         errors++; $display("FAIL resp_preword ready=%b rdata=%h want 1/cafef00d", mem_ready_o, mem_rdata_o);
      end
      rst = 1'b1; mem_valid_i = 1'b0;
      #1;
      checks++;
      if (mem_ready_o !== 1'b0 || mem_rdata_o !== 32'h0) begin
         errors++; $display("FAIL async_reset ready=%b rdata=%h want 0/00000000", mem_ready_o, mem_rdata_o);
      end
      @(negedge clk);
      rst = 1'b0; lfsr_m = 8'hA5;
      @(negedge clk);
      ex = ref_xfer(32'h40, 32'h0, 4'h0, eo); el = LAT + next_extra();
      do_xfer(32'h40, 32'h0, 4'h0, 1'b0, rd, er, lat, p);
      checks++;
      if (rd !== 32'hCAFEF00D || lat != el) begin errors++; $display("FAIL resp_reset_nowrite rdata=%h lat=%0d want cafef00d/%0d", rd, lat, el); end
   endtask

   task automatic test_random();
      logic [31:0] pool [16];
      logic [31:0] oob [4];
      logic [31:0] rd, ex, a, wd; logic [3:0] we; logic er, eo; int lat, el; bit p, hold;
      for (int i = 0; i < 15; i++) pool[i] = 32'h100 + 32'(4 * i);
      pool[15] = 32'h3FFC;
      oob[0] = 32'h4000; oob[1] = 32'h4004; oob[2] = 32'hFFFF_FFFC; oob[3] = 32'h8000_0000;
      for (int i = 0; i < 16; i++) begin
         wd = $urandom;
         ex = ref_xfer(pool[i], wd, 4'hF, eo); el = LAT + next_extra();
         do_xfer(pool[i], wd, 4'hF, 1'b0, rd, er, lat, p);
         checks++;
         if (er !== 1'b0 || lat != el) begin errors++; $display("FAIL rnd_init[%0d] err=%b lat=%0d want 0/%0d", i, er, lat, el); end
      end
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 9) < 8) a = pool[$urandom_range(0, 15)];
         else                          a = oob[$urandom_range(0, 3)];
         a    = a | 32'($urandom_range(0, 3));
         we   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         wd   = $urandom;
         hold = 1'($urandom_range(0, 1));
         ex = ref_xfer(a, wd, we, eo); el = LAT + next_extra();
         do_xfer(a, wd, we, hold, rd, er, lat, p);
         checks++;
         if (rd !== ex || er !== eo) begin
            errors++; $display("FAIL rnd_data[%0d] addr=%h we=%h rdata=%h err=%b want %h/%b", i, a, we, rd, er, ex, eo);
         end
         checks++;
         if (lat != el || !p) begin
            errors++; $display("FAIL rnd_timing[%0d] addr=%h lat=%0d pulse=%0b want %0d/1", i, a, lat, p, el);
         end
         if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      mem_valid_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_read_after_reset();
      test_byte_lanes();
      test_back_to_back();
      test_out_of_range();
      test_abort();
      test_reset_mid();
      test_reset_in_resp();
      test_random();
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the core's valid/ready instruction and data memory interfaces; the core drives the requests and this block answers them.
- Holds a word-addressed RAM with byte write enables and a programmable response latency.
- One instance serves the imem port and one serves the dmem port in the SoC and testbench top levels.

Parameters:
ADDR_WIDTH, 32, width of mem_addr_i
WORD_WIDTH, 32, data width; must be 32 (4 byte lanes)
DEPTH_WORDS, 4096, RAM depth in words; power of two
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be DEPTH_WORDS*4 aligned
LATENCY, 1, cycles from request acceptance to the ready pulse; legal range 1..15

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  reset; asynchronous, active-high
mem_valid_i  input  1  request valid; held high by the initiator until ready
mem_ready_o  output  1  one-cycle response strobe
mem_addr_i  input  ADDR_WIDTH  byte address; bits [1:0] ignored
mem_wdata_i  input  WORD_WIDTH  write data, byte lane i = bits [8i+7:8i]
mem_we_i  input  4  byte write enables; 4'b0000 = read
mem_rdata_o  output  WORD_WIDTH  read data; valid only while mem_ready_o=1
err_o  output  1  pulses with mem_ready_o when the address is out of range

Behaviour:
- Protocol: the initiator raises mem_valid_i with addr/wdata/we stable and holds them until it samples mem_ready_o=1. The transfer completes in that cycle.
- Reset (rst=1, asynchronous): state=IDLE, mem_ready_o=0, mem_rdata_o=0, err_o=0, latency counter=0, LFSR=seed.
- RAM contents are not reset. A reset mid-request drops the request and performs no write.
- FSM states: IDLE, WAIT, RESP. All outputs are registered.
- IDLE:
  - mem_valid_i=1 captures addr, wdata and we, computes in_range, loads cnt=LATENCY-1+extra (extra=0 unless the optional feature is on).
  - Goes to RESP if cnt==0, otherwise to WAIT.
- WAIT: decrement cnt each cycle; go to RESP when cnt reaches 0.
- RESP: mem_ready_o=1 for exactly one cycle, then IDLE.
  - Read in range: mem_rdata_o = RAM[idx].
  - Write in range: for each set we bit, the lane is written at the clock edge that ends RESP.
  - Out of range: err_o=1, mem_rdata_o=0, no write.
- Word index: idx = (addr - BASE_ADDR) >> 2. in_range = (addr - BASE_ADDR) < DEPTH_WORDS*4, using unsigned wrap arithmetic.
- Timing: with valid first sampled at edge t, ready is high in cycle t+LATENCY+extra. Throughput is one transfer per LATENCY+1+extra cycles.
- Back-to-back: a valid still high in the first IDLE cycle after RESP is a new request, even if addr and we are unchanged.
- Abort: if mem_valid_i falls while in WAIT, return to IDLE with no ready and no write. This is a protocol violation; the bench flags it.
- mem_rdata_o is 0 in every cycle where mem_ready_o=0.
- Partial write: lanes with a cleared we bit keep their old contents. mem_rdata_o during a write RESP returns the pre-write word.
- Read-after-write to the same address in the next transaction returns the new data.

Optional Feature:
- Macro: MEM_RESPONDER_JITTER_EN.
- When defined, an 8-bit Fibonacci LFSR adds wait states:
  - Polynomial x^8+x^6+x^5+x^4+1, seed 8'hA5.
  - Advances once per request accepted in IDLE.
  - extra = LFSR[1:0] sampled before the advance (0..3 cycles).
- When undefined: extra=0 and no LFSR flops exist.

Test Plan:
- Reset then read: rst pulse, LATENCY=1, read addr 0x0 -> ready one cycle after valid, rdata=0x00000000 (uninitialised RAM cleared by bench backdoor), err_o=0.
- Byte-lane write: write 0xDEADBEEF with we=4'hF to 0x10, then we=4'b0010 wdata 0x0000AA00, then read 0x10 -> rdata=0xDEADAAEF.
- Latency sweep: LATENCY=3, valid held high continuously across 4 reads -> each ready exactly 3 cycles after acceptance, 4 cycles apart, one-cycle pulses.
- Out of range: DEPTH_WORDS=4096, read and write addr 0x4000 -> ready with err_o=1, rdata=0, no RAM location modified.
- Reset mid-op: LATENCY=4, write issued, rst asserted two cycles later -> ready never pulses, target word unchanged, outputs 0 asynchronously.
- Jitter (MEM_RESPONDER_JITTER_EN): 8 back-to-back reads -> ready delays equal LATENCY+LFSR[1:0] per the seed-8'hA5 sequence, data correct for each.
